// File: rtl/softmax_seq.sv
// Softmax sequencer: buffers an N-element FP32 vector, drives external exp/add/div
// units element by element, and streams the normalised results back out.
module softmax_seq #(
  parameter int N      = 13,
  parameter int IDX_W  = $clog2(N),
  parameter bit STABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        exp_start,
  output logic [31:0] exp_x,
  input  logic        exp_done,
  input  logic [31:0] exp_y,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_s,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_y
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    PREP,
    EXP_GO,
    EXP_WAIT,
    ACC,
    DIV_GO,
    DIV_WAIT,
    OUT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       max_r;
  logic [31:0]       sum_r;
  logic              wait_armed;
  logic [31:0]       x_buf [N];
  logic [31:0]       e_buf [N];

  logic idx_last;
  logic in_fire;
  logic out_fire;
  logic exp_fire;
  logic div_fire;

  // Sign-magnitude ordering on raw FP32 bits; +0 outranks -0.
  function automatic logic beats(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) begin
      return ~a[31];
    end else if (!a[31]) begin
      return a[30:0] > b[30:0];
    end else begin
      return a[30:0] < b[30:0];
    end
  endfunction

  assign idx_last = (idx == LAST_IDX);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // A done level left over from the previous operation is ignored for one cycle.
  assign exp_fire = (state == EXP_WAIT) && wait_armed && exp_done;
  assign div_fire = (state == DIV_WAIT) && wait_armed && div_done;

  assign busy  = ~in_ready;
  assign div_a = e_buf[idx];
  assign div_b = sum_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    exp_start  = 1'b0;
    div_start  = 1'b0;
    add_a      = 32'd0;
    add_b      = 32'd0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && idx_last) state_next = PREP;
      end
      PREP: begin
        if (STABLE) begin
          add_a = x_buf[idx];
          add_b = {~max_r[31], max_r[30:0]};
        end
        state_next = EXP_GO;
      end
      EXP_GO: begin
        exp_start  = 1'b1;
        state_next = EXP_WAIT;
      end
      EXP_WAIT: begin
        if (exp_fire) state_next = ACC;
      end
      ACC: begin
        add_a      = e_buf[idx];
        add_b      = sum_r;
        state_next = idx_last ? DIV_GO : PREP;
      end
      DIV_GO: begin
        div_start  = 1'b1;
        state_next = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (div_fire) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = idx_last ? IDLE : DIV_GO;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; everything is cleared again when the last result leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      max_r      <= 32'd0;
      sum_r      <= 32'd0;
      exp_x      <= 32'd0;
      out_data   <= 32'd0;
      out_last   <= 1'b0;
      wait_armed <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            max_r <= in_data;
            idx   <= IDX_W'(1);
          end
        end
        LOAD: begin
          if (in_fire) begin
            if (beats(in_data, max_r)) max_r <= in_data;
            if (idx_last) begin
              idx   <= '0;
              sum_r <= 32'd0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PREP: begin
          exp_x <= STABLE ? add_s : x_buf[idx];
        end
        EXP_GO: begin
          wait_armed <= 1'b0;
        end
        EXP_WAIT: begin
          wait_armed <= 1'b1;
        end
        ACC: begin
          sum_r <= add_s;
          idx   <= idx_last ? '0 : idx + 1'b1;
        end
        DIV_GO: begin
          wait_armed <= 1'b0;
        end
        DIV_WAIT: begin
          wait_armed <= 1'b1;
          if (div_fire) begin
            out_data <= div_y;
            out_last <= idx_last;
          end
        end
        OUT: begin
          if (out_fire) begin
            if (idx_last) begin
              idx      <= '0;
              out_data <= 32'd0;
              out_last <= 1'b0;
              exp_x    <= 32'd0;
              sum_r    <= 32'd0;
              max_r    <= 32'd0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Vector storage has no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) x_buf[idx] <= in_data;
    if (exp_fire) e_buf[idx] <= exp_y;
  end

endmodule

// File: tb/tb_softmax_seq.sv
// Directed bench for softmax_seq: behavioural FP exp/add/div units around an N=4
// instance, hand-computed vectors, backpressure, sticky done levels and mid-run reset.
`timescale 1ns/1ps
module tb_softmax_seq;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        exp_start;
  logic [31:0] exp_x;
  logic        exp_done = 1'b0;
  logic [31:0] exp_y = 32'd0;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_s;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done = 1'b0;
  logic [31:0] div_y = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  softmax_seq #(.N(N), .IDX_W(IDX_W), .STABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy),
    .exp_start(exp_start), .exp_x(exp_x), .exp_done(exp_done), .exp_y(exp_y),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_y(div_y)
  );

  always #5 clk = ~clk;

  // FP32 <-> real conversion (normals and zeros; subnormals flush to zero).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [23:0] m;
    logic [28:0] rem;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
    m   = {1'b0, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = 24'd0;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] fexp(input logic [31:0] a);
    return r2f($exp(f2r(a)));
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) / f2r(b));
  endfunction

  // Combinational adder unit.
  always_comb add_s = fadd(add_a, add_b);

  // Exp and divider units: fixed latency, done held for a configurable number of
  // cycles and only dropped one cycle after the next start.
  int exp_lat = 3;
  int exp_hold = 1;
  int div_lat = 4;
  int div_hold = 1;
  logic exp_busy = 1'b0;
  logic div_busy = 1'b0;
  int exp_cnt = 0;
  int exp_hold_cnt = 0;
  int div_cnt = 0;
  int div_hold_cnt = 0;

  always @(posedge clk) begin
    if (exp_start) begin
      exp_busy <= 1'b1;
      exp_cnt  <= exp_lat;
    end else if (exp_busy) begin
      if (exp_cnt == 1) begin
        exp_busy     <= 1'b0;
        exp_done     <= 1'b1;
        exp_y        <= fexp(exp_x);
        exp_hold_cnt <= exp_hold;
      end else begin
        exp_done <= 1'b0;
        exp_cnt  <= exp_cnt - 1;
      end
    end else if (exp_done) begin
      if (exp_hold_cnt <= 1) exp_done <= 1'b0;
      else exp_hold_cnt <= exp_hold_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (div_start) begin
      div_busy <= 1'b1;
      div_cnt  <= div_lat;
    end else if (div_busy) begin
      if (div_cnt == 1) begin
        div_busy     <= 1'b0;
        div_done     <= 1'b1;
        div_y        <= fdiv(div_a, div_b);
        div_hold_cnt <= div_hold;
      end else begin
        div_done <= 1'b0;
        div_cnt  <= div_cnt - 1;
      end
    end else if (div_done) begin
      if (div_hold_cnt <= 1) div_done <= 1'b0;
      else div_hold_cnt <= div_hold_cnt - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Monitor: records start pulses and their operands, and watches for a divide
  // being launched while a result is still waiting to be accepted.
  int exp_pulses = 0;
  int div_pulses = 0;
  logic [31:0] exp_x_q [$];
  logic [31:0] div_b_q [$];

  always @(negedge clk) begin
    if (exp_start) begin
      exp_pulses <= exp_pulses + 1;
      exp_x_q.push_back(exp_x);
    end
    if (div_start) begin
      div_pulses <= div_pulses + 1;
      div_b_q.push_back(div_b);
    end
    if (out_valid) checkOutput("div_start_while_out_valid", {31'd0, div_start}, 32'd0);
  end

  logic [31:0] vec   [N];
  logic [31:0] xexp  [N];
  logic [31:0] e_ref [N];
  logic [31:0] o_ref [N];
  logic [31:0] sum_ref;
  logic [31:0] got      [N];
  logic        got_last [N];

  task automatic computeRef(input logic [31:0] mx);
    logic [31:0] nm;
    logic [31:0] s;
    nm = {~mx[31], mx[30:0]};
    s  = 32'd0;
    for (int i = 0; i < N; i++) begin
      e_ref[i] = fexp(fadd(vec[i], nm));
      s        = fadd(e_ref[i], s);
    end
    sum_ref = s;
    for (int i = 0; i < N; i++) o_ref[i] = fdiv(e_ref[i], s);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = vec[i];
      while (!in_ready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        checkOutput("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
  endtask

  task automatic collectOutputs(input int stall);
    logic [31:0] held_d;
    logic        held_l;
    for (int k = 0; k < N; k++) begin
      int guard;
      guard     = 0;
      out_ready = (stall == 0);
      while (!out_valid && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (!out_valid) begin
        checkOutput("out_valid_timeout", 32'd0, 32'd1);
        out_ready = 1'b1;
        return;
      end
      held_d = out_data;
      held_l = out_last;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_out_data", out_data, held_d);
        checkOutput("stall_out_last", {31'd0, out_last}, {31'd0, held_l});
      end
      out_ready   = 1'b1;
      got[k]      = out_data;
      got_last[k] = out_last;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic runVector(input string name, input int stall);
    int exp_base;
    int div_base;
    int xq_base;
    int bq_base;
    exp_base = exp_pulses;
    div_base = div_pulses;
    xq_base  = exp_x_q.size();
    bq_base  = div_b_q.size();
    $display("[TB] vector %s", name);
    applyStimulus();
    checkOutput({name, "_busy_after_load"}, {31'd0, busy}, 32'd1);
    checkOutput({name, "_in_ready_after_load"}, {31'd0, in_ready}, 32'd0);
    collectOutputs(stall);
    @(negedge clk);
    checkOutput({name, "_exp_pulses"}, 32'(exp_pulses - exp_base), 32'(N));
    checkOutput({name, "_div_pulses"}, 32'(div_pulses - div_base), 32'(N));
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s_exp_x%0d", name, i), exp_x_q[xq_base + i], xexp[i]);
      checkOutput($sformatf("%s_div_b%0d", name, i), div_b_q[bq_base + i], sum_ref);
      checkOutput($sformatf("%s_out%0d", name, i), got[i], o_ref[i]);
      checkOutput($sformatf("%s_last%0d", name, i), {31'd0, got_last[i]}, (i == N - 1) ? 32'd1 : 32'd0);
    end
    checkOutput({name, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({name, "_idle_exp_x"}, exp_x, 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({name, "_out_last"}, {31'd0, out_last}, 32'd0);
    checkOutput({name, "_out_data"}, out_data, 32'd0);
    checkOutput({name, "_exp_start"}, {31'd0, exp_start}, 32'd0);
    checkOutput({name, "_div_start"}, {31'd0, div_start}, 32'd0);
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_exp_x"}, exp_x, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    int guard;
    int exp_snap;
    int div_snap;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    // All zeros: each exp is exp(0)=1, sum 4.0, every output 0.25.
    vec  = '{32'h0, 32'h0, 32'h0, 32'h0};
    xexp = '{32'h0, 32'h0, 32'h0, 32'h0};
    o_ref   = '{32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000};
    sum_ref = 32'h40800000;
    runVector("uniform", 0);

    // 1, 4, -2, 0.5 with max 4: operands -3, 0, -6, -3.5; backpressure on each output.
    vec  = '{32'h3F800000, 32'h40800000, 32'hC0000000, 32'h3F000000};
    xexp = '{32'hC0400000, 32'h00000000, 32'hC0C00000, 32'hC0600000};
    computeRef(32'h40800000);
    runVector("mixed_stall", 5);

    // All negative including -0: -0 is the maximum; units hold done for extra cycles.
    exp_hold = 4;
    div_hold = 4;
    vec  = '{32'hBF800000, 32'hBF000000, 32'hC0400000, 32'h80000000};
    xexp = '{32'hBF800000, 32'hBF000000, 32'hC0400000, 32'h00000000};
    computeRef(32'h80000000);
    runVector("negative_sticky", 0);
    exp_hold = 1;
    div_hold = 1;

    // +0 must win over -0: subtracting +0 leaves -0 as -0.
    vec  = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000};
    xexp = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000};
    computeRef(32'h00000000);
    runVector("signed_zero", 0);

    // Reset while the third divide is in flight, then a clean vector.
    $display("[TB] reset during divide");
    vec = '{32'h3F800000, 32'h40800000, 32'hC0000000, 32'h3F000000};
    applyStimulus();
    out_ready = 1'b1;
    seen  = 0;
    guard = 0;
    while (seen < 3 && guard < 2000) begin
      @(negedge clk);
      if (div_start) seen++;
      guard++;
    end
    checkOutput("reset_mid_third_div_start", 32'(seen), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("mid_reset");
    rst = 1'b0;
    exp_snap = exp_pulses;
    div_snap = div_pulses;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_exp_pulses", 32'(exp_pulses), 32'(exp_snap));
    checkOutput("post_reset_div_pulses", 32'(div_pulses), 32'(div_snap));
    checkOutput("post_reset_out_valid", {31'd0, out_valid}, 32'd0);

    xexp = '{32'hC0400000, 32'h00000000, 32'hC0C00000, 32'hC0600000};
    computeRef(32'h40800000);
    runVector("after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
